// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the data memory.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface dm_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [3:0]  m0_be;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m0_err;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [3:0]  m1_be;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_be, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_be, m1_wdata,
        input  dm_rd,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output dm_we, dm_addr, dm_wd
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_be, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_be, m1_wdata,
        output dm_rd,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  dm_we, dm_addr, dm_wd
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port fixed-priority arbiter for the single-port data memory, with a starvation
// guard for port 1, one-cycle sub-word read-modify-write and a registered response.
module dm_arbiter #(
    parameter int unsigned DM_WORDS = 3072,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    dm_arbiter_if.slave bus
);
    localparam int unsigned LP_CW    = 4;
    localparam logic [31:0] LP_LIMIT = 32'(DM_WORDS * 4);
    localparam logic [LP_CW-1:0] LP_MAX = LP_CW'(MAX_WAIT);

    logic [LP_CW-1:0] r_starve_cnt;
    logic             r_rvalid0, r_rvalid1;
    logic             r_err0, r_err1;
    logic [31:0]      r_rdata0, r_rdata1;

    logic        w_force1, w_gnt0, w_gnt1, w_any;
    logic        w_we, w_be_ok, w_err;
    logic [31:0] w_addr, w_wdata, w_wd;
    logic [3:0]  w_be;

    // Port 1 overrides the fixed priority once it has waited MAX_WAIT cycles
    assign w_force1 = (r_starve_cnt == LP_MAX) && bus.m1_req;
    assign w_gnt1   = bus.m1_req && (w_force1 || !bus.m0_req);
    assign w_gnt0   = bus.m0_req && !w_gnt1;
    assign w_any    = w_gnt0 || w_gnt1;

    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_be    = '0;
        w_wdata = '0;
        if (w_gnt1) begin
            w_we    = bus.m1_we;
            w_addr  = bus.m1_addr;
            w_be    = bus.m1_be;
            w_wdata = bus.m1_wdata;
        end else if (w_gnt0) begin
            w_we    = bus.m0_we;
            w_addr  = bus.m0_addr;
            w_be    = bus.m0_be;
            w_wdata = bus.m0_wdata;
        end
    end

    always_comb begin
        case (w_be)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_be_ok = 1'b1;
            default:                            w_be_ok = 1'b0;
        endcase
    end

    assign w_err = w_any && ((w_addr >= LP_LIMIT) || !w_be_ok);

    // Unselected byte lanes keep the current memory contents
    always_comb begin
        w_wd = bus.dm_rd;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_wd[8*i +: 8] = w_wdata[8*i +: 8];
            end
        end
    end

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.dm_we     = w_any && w_we && !w_err && !reset;
    assign bus.dm_addr   = {w_addr[31:2], 2'b00};
    assign bus.dm_wd     = w_wd;

    assign bus.m0_rvalid = r_rvalid0;
    assign bus.m0_rdata  = r_rdata0;
    assign bus.m0_err    = r_err0;
    assign bus.m1_rvalid = r_rvalid1;
    assign bus.m1_rdata  = r_rdata1;
    assign bus.m1_err    = r_err1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_rvalid0 <= w_gnt0;
            r_rvalid1 <= w_gnt1;
            r_err0    <= w_gnt0 && w_err;
            r_err1    <= w_gnt1 && w_err;
            r_rdata0  <= (w_gnt0 && !w_we && !w_err) ? bus.dm_rd : 32'h0;
            r_rdata1  <= (w_gnt1 && !w_we && !w_err) ? bus.dm_rd : 32'h0;

            if (!bus.m1_req || w_gnt1) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != LP_MAX) begin
                r_starve_cnt <= r_starve_cnt + LP_CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed vector table, multi-cycle sequences
// and a randomized run against a behavioural arbitration/memory model.
module tb_dm_arbiter;
    localparam int unsigned DM_WORDS = 3072;
    localparam int unsigned MAX_WAIT = 4;
    localparam logic [31:0] LIM      = 32'(DM_WORDS * 4);

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    dm_arbiter_if bus ();

    dm_arbiter #(.DM_WORDS(DM_WORDS), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: combinational read, write on the rising edge
    logic [31:0] mem [DM_WORDS];
    always @(posedge clk) begin
        if (bus.dm_we && bus.dm_addr < LIM) mem[bus.dm_addr[13:2]] <= bus.dm_wd;
    end
    assign bus.dm_rd = (bus.dm_addr < LIM) ? mem[bus.dm_addr[13:2]] : 32'hBADC0FFE;

    typedef struct {
        logic r0; logic w0; logic [31:0] a0; logic [3:0] b0; logic [31:0] d0;
        logic r1; logic w1; logic [31:0] a1; logic [3:0] b1; logic [31:0] d1;
        logic g0; logic g1; logic we; logic [31:0] addr; logic [31:0] wd;
        logic err; logic [31:0] rdata;
    } vec_t;
    localparam int NV = 12;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drv(input int p, input logic req, input logic we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] d);
        if (p == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_be = be; bus.m0_wdata = d;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_be = be; bus.m1_wdata = d;
        end
    endtask

    task automatic idle();
        drv(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic be_ok(input logic [3:0] b);
        return b inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    endfunction

    // Random model state
    logic        p_act [2];
    logic        p_we  [2];
    logic [31:0] p_a   [2];
    logic [3:0]  p_be  [2];
    logic [31:0] p_d   [2];
    logic [31:0] ref_mem [64];
    logic [3:0]  legal_be [7];
    int          waited;
    logic        er_v0, er_v1, er_err;
    logic [31:0] er_rd;

    task automatic rand_req(input int p);
        int sel;
        p_we[p] = 1'($urandom_range(0, 1));
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      p_a[p] = 32'h3000 + 32'($urandom_range(0, 255));
        else if (sel == 1) p_a[p] = 32'hFFFF_FFFC;
        else               p_a[p] = 32'h100 + 32'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) p_be[p] = 4'($urandom);
        else                           p_be[p] = legal_be[$urandom_range(0, 6)];
        p_d[p] = $urandom;
    endtask

    initial begin
        logic eg0, eg1, gerr, req1;
        logic [31:0] nw;
        int gp;
        int idx;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        idle();
        legal_be = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid0", 32'(bus.m0_rvalid), 32'h0);
        chk("rst_rvalid1", 32'(bus.m1_rvalid), 32'h0);
        chk("rst_rdata0", bus.m0_rdata, 32'h0);
        chk("rst_rdata1", bus.m1_rdata, 32'h0);
        chk("rst_err", 32'({bus.m0_err, bus.m1_err}), 32'h0);
        chk("rst_dm_we", 32'(bus.dm_we), 32'h0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Store then back-to-back load on port 0
        drv(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        chk("sl_gnt0", 32'(bus.m0_gnt), 32'h1);
        chk("sl_dm_we", 32'(bus.dm_we), 32'h1);
        chk("sl_dm_wd", bus.dm_wd, 32'hDEADBEEF);
        next_cycle();
        drv(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        @(negedge clk);
        chk("sl_st_rvalid", 32'(bus.m0_rvalid), 32'h1);
        chk("sl_st_rdata", bus.m0_rdata, 32'h0);
        chk("sl_ld_dm_we", 32'(bus.dm_we), 32'h0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("sl_ld_rvalid", 32'(bus.m0_rvalid), 32'h1);
        chk("sl_ld_rdata", bus.m0_rdata, 32'hDEADBEEF);
        next_cycle();

        // Vector table: one request, then its response one cycle later
        vt[0]  = '{1'b1,1'b1,32'h20,4'hF,32'h11223344, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b1,1'b0,1'b1,32'h20,32'h11223344,1'b0,32'h0};
        vt[1]  = '{1'b0,1'b0,32'h0,4'h0,32'h0, 1'b1,1'b1,32'h20,4'b0100,32'h00AA0000, 1'b0,1'b1,1'b1,32'h20,32'h11AA3344,1'b0,32'h0};
        vt[2]  = '{1'b0,1'b0,32'h0,4'h0,32'h0, 1'b1,1'b0,32'h20,4'hF,32'h0, 1'b0,1'b1,1'b0,32'h20,32'h0,1'b0,32'h11AA3344};
        vt[3]  = '{1'b1,1'b0,32'h3000,4'hF,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b1,1'b0,1'b0,32'h3000,32'h0,1'b1,32'h0};
        vt[4]  = '{1'b1,1'b1,32'h10,4'b0101,32'h12345678, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b1,1'b0,1'b0,32'h10,32'h0,1'b1,32'h0};
        vt[5]  = '{1'b1,1'b1,32'h2FFC,4'hF,32'hCAFE00A5, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b1,1'b0,1'b1,32'h2FFC,32'hCAFE00A5,1'b0,32'h0};
        vt[6]  = '{1'b0,1'b0,32'h0,4'h0,32'h0, 1'b1,1'b1,32'h23,4'b1000,32'h77000000, 1'b0,1'b1,1'b1,32'h20,32'h77AA3344,1'b0,32'h0};
        vt[7]  = '{1'b0,1'b0,32'h0,4'h0,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0};
        vt[8]  = '{1'b1,1'b0,32'h22,4'b0011,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b1,1'b0,1'b0,32'h20,32'h0,1'b0,32'h77AA3344};
        vt[9]  = '{1'b1,1'b0,32'h2FFC,4'hF,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b1,1'b0,1'b0,32'h2FFC,32'h0,1'b0,32'hCAFE00A5};
        vt[10] = '{1'b1,1'b0,32'h10,4'hF,32'h0, 1'b0,1'b0,32'h0,4'h0,32'h0, 1'b1,1'b0,1'b0,32'h10,32'h0,1'b0,32'hDEADBEEF};
        vt[11] = '{1'b0,1'b0,32'h0,4'h0,32'h0, 1'b1,1'b0,32'h3004,4'hF,32'h0, 1'b0,1'b1,1'b0,32'h3004,32'h0,1'b1,32'h0};
        for (int i = 0; i < NV; i++) begin
            drv(0, vt[i].r0, vt[i].w0, vt[i].a0, vt[i].b0, vt[i].d0);
            drv(1, vt[i].r1, vt[i].w1, vt[i].a1, vt[i].b1, vt[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i), 32'(bus.m0_gnt), 32'(vt[i].g0));
            chk($sformatf("v%0d_gnt1", i), 32'(bus.m1_gnt), 32'(vt[i].g1));
            chk($sformatf("v%0d_dm_we", i), 32'(bus.dm_we), 32'(vt[i].we));
            chk($sformatf("v%0d_dm_addr", i), bus.dm_addr, vt[i].addr);
            if (vt[i].we) chk($sformatf("v%0d_dm_wd", i), bus.dm_wd, vt[i].wd);
            next_cycle();
            idle();
            @(negedge clk);
            chk($sformatf("v%0d_rvalid0", i), 32'(bus.m0_rvalid), 32'(vt[i].g0));
            chk($sformatf("v%0d_rvalid1", i), 32'(bus.m1_rvalid), 32'(vt[i].g1));
            if (vt[i].g0) begin
                chk($sformatf("v%0d_err0", i), 32'(bus.m0_err), 32'(vt[i].err));
                chk($sformatf("v%0d_rdata0", i), bus.m0_rdata, vt[i].rdata);
            end else if (vt[i].g1) begin
                chk($sformatf("v%0d_err1", i), 32'(bus.m1_err), 32'(vt[i].err));
                chk($sformatf("v%0d_rdata1", i), bus.m1_rdata, vt[i].rdata);
            end
            next_cycle();
        end

        // Starvation: both ports request continuously
        drv(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        drv(1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk($sformatf("stv%0d_gnt1", k), 32'(bus.m1_gnt), 32'((k % 5) == 4));
            chk($sformatf("stv%0d_gnt0", k), 32'(bus.m0_gnt), 32'((k % 5) != 4));
            if (k > 0) chk($sformatf("stv%0d_rvalid1", k), 32'(bus.m1_rvalid), 32'(((k - 1) % 5) == 4));
            next_cycle();
        end
        idle();
        next_cycle();

        // Reset during a granted port 1 store
        drv(0, 1'b1, 1'b1, 32'h24, 4'hF, 32'h01020304);
        next_cycle();
        idle();
        next_cycle();
        drv(1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        next_cycle();
        drv(1, 1'b1, 1'b1, 32'h24, 4'b0001, 32'h000000EE);
        #1;
        chk("rma_pre_rvalid1", 32'(bus.m1_rvalid), 32'h1);
        chk("rma_pre_gnt1", 32'(bus.m1_gnt), 32'h1);
        chk("rma_pre_dm_we", 32'(bus.dm_we), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("rma_dm_we", 32'(bus.dm_we), 32'h0);
        chk("rma_rvalid1", 32'(bus.m1_rvalid), 32'h0);
        chk("rma_rdata1", bus.m1_rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rma_post_gnt1", 32'(bus.m1_gnt), 32'h1);
        chk("rma_post_dm_we", 32'(bus.dm_we), 32'h1);
        chk("rma_post_dm_wd", bus.dm_wd, 32'h010203EE);
        chk("rma_mem_kept", mem[9], 32'h01020304);
        next_cycle();
        idle();
        @(negedge clk);
        chk("rma_post_rvalid1", 32'(bus.m1_rvalid), 32'h1);
        chk("rma_post_err1", 32'(bus.m1_err), 32'h0);
        next_cycle();

        // Reset pulse must also clear the accumulated wait of port 1
        drv(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        drv(1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
        next_cycle();
        next_cycle();
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rcnt%0d_gnt1", k), 32'(bus.m1_gnt), 32'(k == 4));
            next_cycle();
        end
        idle();
        next_cycle();

        // Randomized run: initialise the model window, then free-running traffic
        for (int w = 0; w < 64; w++) begin
            drv(0, 1'b1, 1'b1, 32'h100 + 32'(4 * w), 4'hF, 32'h0);
            ref_mem[w] = 32'h0;
            next_cycle();
        end
        idle();
        next_cycle();
        p_act  = '{1'b0, 1'b0};
        waited = 0;
        er_v0  = 1'b0;
        er_v1  = 1'b0;
        er_err = 1'b0;
        er_rd  = 32'h0;
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_act[p] && $urandom_range(0, 99) < 55) begin
                    p_act[p] = 1'b1;
                    rand_req(p);
                end
            end
            drv(0, p_act[0], p_we[0], p_a[0], p_be[0], p_d[0]);
            drv(1, p_act[1], p_we[1], p_a[1], p_be[1], p_d[1]);
            @(negedge clk);
            eg1 = p_act[1] && (waited >= int'(MAX_WAIT) || !p_act[0]);
            eg0 = p_act[0] && !eg1;
            chk("rnd_gnt0", 32'(bus.m0_gnt), 32'(eg0));
            chk("rnd_gnt1", 32'(bus.m1_gnt), 32'(eg1));
            chk("rnd_rvalid0", 32'(bus.m0_rvalid), 32'(er_v0));
            chk("rnd_rvalid1", 32'(bus.m1_rvalid), 32'(er_v1));
            if (er_v0) begin
                chk("rnd_err0", 32'(bus.m0_err), 32'(er_err));
                chk("rnd_rdata0", bus.m0_rdata, er_rd);
            end
            if (er_v1) begin
                chk("rnd_err1", 32'(bus.m1_err), 32'(er_err));
                chk("rnd_rdata1", bus.m1_rdata, er_rd);
            end
            req1   = p_act[1];
            er_v0  = eg0;
            er_v1  = eg1;
            er_err = 1'b0;
            er_rd  = 32'h0;
            if (eg0 || eg1) begin
                gp   = eg1 ? 1 : 0;
                gerr = (p_a[gp] >= LIM) || !be_ok(p_be[gp]);
                chk("rnd_dm_addr", bus.dm_addr, {p_a[gp][31:2], 2'b00});
                chk("rnd_dm_we", 32'(bus.dm_we), 32'(p_we[gp] && !gerr));
                if (!gerr) begin
                    idx = int'((p_a[gp] - 32'h100) >> 2);
                    if (p_we[gp]) begin
                        nw = ref_mem[idx];
                        for (int b = 0; b < 4; b++)
                            if (p_be[gp][b]) nw[8*b +: 8] = p_d[gp][8*b +: 8];
                        chk("rnd_dm_wd", bus.dm_wd, nw);
                        ref_mem[idx] = nw;
                    end else begin
                        er_rd = ref_mem[idx];
                    end
                end
                er_err    = gerr;
                p_act[gp] = 1'b0;
            end else begin
                chk("rnd_idle_dm_we", 32'(bus.dm_we), 32'h0);
            end
            waited = (req1 && !eg1) ? waited + 1 : 0;
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("rnd_last_rvalid0", 32'(bus.m0_rvalid), 32'(er_v0));
        chk("rnd_last_rvalid1", 32'(bus.m1_rvalid), 32'(er_v1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and access sequencer placed in front of the single-port data memory in the M stage. It shares the memory between the CPU memory stage (port 0) and a DMA/debug loader (port 1). It merges sub-word writes into the memory word and returns registered read data with a one-cycle response. Port 0 has fixed priority; a starvation counter guarantees port 1 a bounded wait.

## Interface
- `DM_WORDS`, 3072: number of 32-bit words backing the memory; the legal byte range is `0 .. DM_WORDS*4-1`.
- `MAX_WAIT`, 4: maximum number of consecutive cycles port 1 may be refused while requesting (1..15).
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `m0_req` / `m1_req` in 1: access request; must be held with a stable payload until `mX_gnt`.
- `m0_we` / `m1_we` in 1: 1 = store, 0 = load.
- `m0_addr` / `m1_addr` in 32: byte address; bits [1:0] are ignored for addressing.
- `m0_be` / `m1_be` in 4: byte enables. Legal values: 1111, 0011, 1100, 0001, 0010, 0100, 1000.
- `m0_wdata` / `m1_wdata` in 32: store data, already lane-aligned to `be`.
- `m0_gnt` / `m1_gnt` out 1: combinational grant; the access is issued in this cycle.
- `m0_rvalid` / `m1_rvalid` out 1: registered one-cycle response strobe.
- `m0_rdata` / `m1_rdata` out 32: full read word for loads; 0 for stores and errors.
- `m0_err` / `m1_err` out 1: valid with `rvalid`; set for an out-of-range address or illegal `be`.
- `dm_we` out 1: memory write enable.
- `dm_addr` out 32: word-aligned byte address `{addr[31:2],2'b00}` of the granted request; 0 when idle.
- `dm_wd` out 32: merged write word.
- `dm_rd` in 32: combinational memory read of `dm_addr`.

## Operation
- **Arbitration.** Evaluated every cycle; at most one grant per cycle.
  - If `starve_cnt == MAX_WAIT` and `m1_req` is high, port 1 is granted.
  - Otherwise, if `m0_req` is high, port 0 is granted.
  - Otherwise, if `m1_req` is high, port 1 is granted.
- **Starvation counter.** `starve_cnt` is 4 bits.
  - It increments when `m1_req` is high and `m1_gnt` is low.
  - It clears when `m1_gnt` is high or `m1_req` is low.
  - It saturates at `MAX_WAIT`.
- **Error check.** A granted request has `err = (addr >= DM_WORDS*4) | (be not legal)`.
- **Write path.**
  - `dm_we = granted & we & !err & !reset`.
  - `dm_wd` byte lane i is `wdata[8i+7:8i]` when `be[i]` is set, otherwise `dm_rd[8i+7:8i]` (read-modify-write in one cycle).
- **Error behaviour.** An erroneous request is still granted. It writes nothing and returns `err=1` with `rdata=0`.
- **Response.** On the edge after a grant:
  - `rvalid` is set for the granted port only.
  - `rdata` is the `dm_rd` value captured at grant for loads, and 0 for stores.
  - Sub-word extraction and sign extension are done by the requester.
- **Reset values.** All `rvalid`, `rdata`, `err` outputs are 0; `starve_cnt` is 0. Because `dm_we` is gated by `reset`, no write occurs while `reset` is high.

## Timing
- Grant latency is 0 cycles: same cycle as `req` when the port wins arbitration.
- Response latency is exactly 1 cycle after `gnt`; `rvalid` is high for one cycle.
- Throughput is one access per cycle total. Back-to-back grants to the same port produce back-to-back `rvalid`.
- A store followed by a load to the same word in the next cycle returns the new data, since the memory updates on the grant edge.
- **Simultaneous requests.** Port 0 wins until port 1 has waited `MAX_WAIT` cycles. Port 1 is then granted in the next cycle in which it requests, so its worst-case wait is `MAX_WAIT` cycles.
- **Reset mid-operation.** A pending response is dropped; `rvalid` falls immediately (asynchronous). A request held across reset is re-arbitrated after reset deasserts.
- A requester dropping `req` before `gnt` is a protocol violation and has no defined response.

## Test plan
- **Port 0 store then load.** Stimulus: port 0 stores addr 0x10, be 1111, wdata 0xDEADBEEF; next cycle, port 0 loads 0x10. Required: `dm_we=1`, `dm_wd=0xDEADBEEF` in cycle 0; `m0_rvalid=1`, `m0_rdata=0xDEADBEEF` in cycle 2.
- **Byte merge.** Stimulus: word 0x20 holds 0x11223344; port 1 stores be 0100, wdata 0x00AA0000. Required: `dm_wd=0x11AA3344`; `m1_rvalid=1` and `m1_err=0` next cycle.
- **Starvation.** Stimulus: `MAX_WAIT=4`; `m0_req` and `m1_req` both held high continuously. Required:
  - `m0_gnt` in cycles 0-3, `m1_gnt` in cycle 4.
  - The pattern then repeats with a period of 5.
- **Errors.** Stimulus: port 0 load at 0x3000 (=DM_WORDS*4); port 0 store with be 0101. Required: `dm_we=0` in both cases; `m0_err=1` and `m0_rdata=0` on each response.
- **Reset mid-access.** Stimulus: assert `reset` asynchronously during a granted port 1 store. Required:
  - `dm_we=0` immediately; the memory word is unchanged.
  - `m1_rvalid=0`; `starve_cnt=0`.
  - The request is granted on the first cycle after reset release.
